// File: rtl/dg0045_rom_responder.sv
// Program-memory responder for the DG0045 multiplexed ROM fetch bus.
// It samples the PC in two halves, reads the program store and returns the byte; a load port fills the store.
module dg0045_rom_responder #(
    parameter int DEPTH  = 1024,
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] pc_hl,
    output logic       pc_mux,
    output logic [7:0] rom_data,
    output logic       fetch_stb,
    output logic [9:0] fetch_addr,
    input  logic       prog_en,
    input  logic       prog_clr,
    input  logic       prog_valid,
    input  logic [7:0] prog_data,
    output logic       prog_ready,
    output logic [9:0] prog_ptr
);

    typedef enum logic [1:0] {ST_LO, ST_HI, ST_RD} state_t;

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [10:0] DEPTH_W   = 11'(DEPTH);
    localparam logic [9:0]  LAST_ADDR = 10'(DEPTH - 1);
    localparam logic [2:0]  SETTLE_C  = 3'(SETTLE);

    logic [7:0] mem [DEPTH];

    state_t     state;
    logic [2:0] cnt;
    logic [4:0] lo_q;
    logic [4:0] hi_q;
    logic [9:0] addr;
    logic [9:0] wr_addr;
    logic       accept;

    assign addr       = {hi_q, lo_q};
    assign prog_ready = prog_en;
    assign accept     = prog_en & prog_valid;
    // A clear in the same cycle as an accept redirects that write to address 0.
    assign wr_addr    = prog_clr ? 10'd0 : prog_ptr;

    // NOTE: the program store has no reset; contents survive rst_n and only the load port changes them.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_addr[AW-1:0]] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_ptr <= '0;
        end else if (accept) begin
            prog_ptr <= (wr_addr == LAST_ADDR) ? 10'd0 : wr_addr + 10'd1;
        end else if (prog_clr) begin
            prog_ptr <= '0;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_LO;
            cnt        <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            pc_mux     <= 1'b0;
            rom_data   <= 8'h00;
            fetch_stb  <= 1'b0;
            fetch_addr <= '0;
        end else if (prog_en) begin
            // Park the sequencer and feed the core NOPs while the store is being written.
            state     <= ST_LO;
            cnt       <= '0;
            pc_mux    <= 1'b0;
            rom_data  <= 8'h00;
            fetch_stb <= 1'b0;
        end else begin
            fetch_stb <= 1'b0;
            unique case (state)
                ST_LO: begin
                    if (cnt == SETTLE_C) begin
                        lo_q   <= pc_hl;
                        cnt    <= '0;
                        state  <= ST_HI;
                        pc_mux <= 1'b1;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ST_HI: begin
                    if (cnt == SETTLE_C) begin
                        hi_q   <= pc_hl;
                        cnt    <= '0;
                        state  <= ST_RD;
                        pc_mux <= 1'b0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ST_RD: begin
                    rom_data   <= ({1'b0, addr} < DEPTH_W) ? mem[addr[AW-1:0]] : 8'h00;
                    fetch_addr <= addr;
                    fetch_stb  <= 1'b1;
                    state      <= ST_LO;
                end
                default: begin
                    state  <= ST_LO;
                    cnt    <= '0;
                    pc_mux <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dg0045_rom_responder.sv
// Directed bench for dg0045_rom_responder: a small core model drives pc_hl from a target PC
// according to pc_mux, and each scenario task checks the responder's outputs inline.
module tb_dg0045_rom_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] pc_hl;
    logic       pc_mux;
    logic [7:0] rom_data;
    logic       fetch_stb;
    logic [9:0] fetch_addr;
    logic       prog_en = 1'b0;
    logic       prog_clr = 1'b0;
    logic       prog_valid = 1'b0;
    logic [7:0] prog_data = 8'h00;
    logic       prog_ready;
    logic [9:0] prog_ptr;

    logic [9:0] pc_target = 10'h3FF;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Core model: low half PL[4:0] when pc_mux=0, high half {PU,PL[5]} when pc_mux=1.
    assign pc_hl = pc_mux ? pc_target[9:5] : pc_target[4:0];

    dg0045_rom_responder #(.DEPTH(256), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .pc_hl(pc_hl), .pc_mux(pc_mux),
        .rom_data(rom_data), .fetch_stb(fetch_stb), .fetch_addr(fetch_addr),
        .prog_en(prog_en), .prog_clr(prog_clr), .prog_valid(prog_valid),
        .prog_data(prog_data), .prog_ready(prog_ready), .prog_ptr(prog_ptr)
    );

    task automatic wait_stb(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (fetch_stb === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: fetch_stb not seen within 40 cycles, required a pulse", name);
        end
    endtask

    task automatic fetch_at(input logic [9:0] pc, input logic [7:0] exp_data, input string name);
        pc_target = pc;
        wait_stb(name);
        wait_stb(name);
        checks++;
        if (fetch_addr !== pc) begin
            errors++;
            $display("FAIL %s fetch_addr: got %h, expected %h", name, fetch_addr, pc);
        end
        checks++;
        if (rom_data !== exp_data) begin
            errors++;
            $display("FAIL %s rom_data: got %h, expected %h", name, rom_data, exp_data);
        end
    endtask

    task automatic load_byte(input logic [7:0] d);
        prog_valid = 1'b1;
        prog_data  = d;
        @(negedge clk);
        prog_valid = 1'b0;
    endtask

    task automatic check_ptr(input logic [9:0] exp, input string name);
        checks++;
        if (prog_ptr !== exp) begin
            errors++;
            $display("FAIL %s prog_ptr: got %0d, expected %0d", name, prog_ptr, exp);
        end
    endtask

    task automatic test_reset();
        bit hi_seen = 1'b0;
        #12;
        checks++;
        if ({pc_mux, rom_data, fetch_stb, fetch_addr, prog_ptr} !== 29'd0) begin
            errors++;
            $display("FAIL reset_state: got mux=%b data=%h stb=%b addr=%h ptr=%h, expected all zero",
                     pc_mux, rom_data, fetch_stb, fetch_addr, prog_ptr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20 && !hi_seen; i++) begin
            @(negedge clk);
            if (pc_mux === 1'b1) hi_seen = 1'b1;
        end
        checks++;
        if (!hi_seen) begin
            errors++;
            $display("FAIL reset_reach_hi: pc_mux stayed %b, expected 1 within 20 cycles", pc_mux);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pc_mux, rom_data, fetch_stb} !== 10'd0) begin
            errors++;
            $display("FAIL reset_mid_hi: got mux=%b data=%h stb=%b, expected 0/00/0",
                     pc_mux, rom_data, fetch_stb);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (pc_mux !== 1'b0) begin
            errors++;
            $display("FAIL reset_restart_lo: pc_mux got %b, expected 0", pc_mux);
        end
        @(negedge clk);
        checks++;
        if (pc_mux !== 1'b1) begin
            errors++;
            $display("FAIL reset_restart_hi: pc_mux got %b, expected 1", pc_mux);
        end
    endtask

    task automatic test_load();
        prog_en = 1'b1;
        @(negedge clk);
        checks++;
        if (prog_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready: prog_ready got %b, expected 1", prog_ready);
        end
        load_byte(8'hA5);
        load_byte(8'h3C);
        load_byte(8'h81);
        load_byte(8'hC2);
        check_ptr(10'd4, "load_four");
        checks++;
        if ({rom_data, fetch_stb, pc_mux} !== 10'd0) begin
            errors++;
            $display("FAIL load_quiet: got data=%h stb=%b mux=%b, expected 00/0/0",
                     rom_data, fetch_stb, pc_mux);
        end
    endtask

    task automatic test_fetch();
        int mux_cnt = 0;
        int stb_cnt = 0;
        pc_target = 10'h002;
        prog_en = 1'b0;
        wait_stb("fetch_first");
        checks++;
        if (rom_data !== 8'h81 || fetch_addr !== 10'h002) begin
            errors++;
            $display("FAIL fetch_pc2: got data=%h addr=%h, expected 81/002", rom_data, fetch_addr);
        end
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (pc_mux === 1'b1) mux_cnt++;
            if (i < 5 && fetch_stb !== 1'b0) stb_cnt++;
            if (i == 3) begin
                checks++;
                if (rom_data !== 8'h81) begin
                    errors++;
                    $display("FAIL fetch_hold: rom_data got %h mid-loop, expected 81", rom_data);
                end
            end
        end
        checks++;
        if (mux_cnt != 2) begin
            errors++;
            $display("FAIL fetch_mux_width: pc_mux high %0d cycles per loop, expected 2", mux_cnt);
        end
        checks++;
        if (stb_cnt != 0 || fetch_stb !== 1'b1) begin
            errors++;
            $display("FAIL fetch_period: extra pulses=%0d, stb at cycle 5=%b, expected 0 and 1",
                     stb_cnt, fetch_stb);
        end
    endtask

    task automatic test_split();
        fetch_at(10'h3F3, 8'h00, "split_3f3");
    endtask

    task automatic test_depth();
        fetch_at(10'h100, 8'h00, "depth_oob");
        prog_en  = 1'b1;
        prog_clr = 1'b1;
        @(negedge clk);
        prog_clr = 1'b0;
        check_ptr(10'd0, "depth_clr");
        for (int i = 0; i < 256; i++) load_byte(8'(i) ^ 8'h5A);
        check_ptr(10'd0, "depth_wrap256");
        load_byte(8'hE7);
        check_ptr(10'd1, "depth_wrap257");
        prog_en = 1'b0;
        fetch_at(10'h0FF, 8'hA5, "depth_last");
        fetch_at(10'h000, 8'hE7, "depth_overwrite0");
        fetch_at(10'h001, 8'h5B, "depth_addr1");
    endtask

    task automatic test_clr();
        prog_en  = 1'b1;
        prog_clr = 1'b1;
        @(negedge clk);
        prog_clr = 1'b0;
        for (int i = 0; i < 9; i++) load_byte(8'h20 + 8'(i));
        check_ptr(10'd9, "clr_at9");
        prog_clr   = 1'b1;
        prog_valid = 1'b1;
        prog_data  = 8'h7E;
        @(negedge clk);
        prog_clr   = 1'b0;
        prog_valid = 1'b0;
        check_ptr(10'd1, "clr_with_accept");
        prog_en = 1'b0;
        fetch_at(10'h000, 8'h7E, "clr_addr0");
        fetch_at(10'h009, 8'h53, "clr_addr9_untouched");
        fetch_at(10'h008, 8'h28, "clr_addr8");
        prog_clr = 1'b1;
        @(negedge clk);
        prog_clr = 1'b0;
        check_ptr(10'd0, "clr_fetch_mode");
        prog_valid = 1'b1;
        prog_data  = 8'hFF;
        repeat (2) @(negedge clk);
        prog_valid = 1'b0;
        check_ptr(10'd0, "valid_ignored");
        fetch_at(10'h000, 8'h7E, "valid_ignored_mem");
    endtask

    task automatic test_prog_en_mid_rd();
        bit bad_stb = 1'b0;
        bit bad_mux = 1'b0;
        int gap = 0;
        bit seen = 1'b0;
        pc_target = 10'h000;
        wait_stb("mid_rd_sync");
        repeat (4) @(negedge clk);
        prog_en = 1'b1;
        @(negedge clk);
        checks++;
        if (rom_data !== 8'h00 || fetch_stb !== 1'b0) begin
            errors++;
            $display("FAIL mid_rd_nop: got data=%h stb=%b, expected 00/0", rom_data, fetch_stb);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fetch_stb !== 1'b0) bad_stb = 1'b1;
            if (pc_mux !== 1'b0) bad_mux = 1'b1;
        end
        checks++;
        if (bad_stb || bad_mux) begin
            errors++;
            $display("FAIL mid_rd_suspend: stb pulsed=%b mux raised=%b, expected 0/0", bad_stb, bad_mux);
        end
        prog_en = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (fetch_stb === 1'b1) begin
                seen = 1'b1;
                gap  = i;
            end
        end
        checks++;
        if (!seen || gap != 5 || rom_data !== 8'h7E) begin
            errors++;
            $display("FAIL resume_first_stb: seen=%b after %0d cycles data=%h, expected 1/5/7E",
                     seen, gap, rom_data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load();
        test_fetch();
        test_split();
        test_depth();
        test_clr();
        test_prog_en_mid_rd();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
